// File: rtl/knn_ctrl.sv
// knn_ctrl: sequences point RAM reads through the distance core and keeps a sorted K-nearest list
module knn_ctrl #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8,
  parameter int K      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IDX_W:0]        n_points,
  input  logic [DATA_W-1:0]     test_point,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ren,
  output logic [IDX_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  core_en,
  output logic [DATA_W-1:0]     core_A,
  output logic [DATA_W-1:0]     core_B,
  input  logic [DATA_W-1:0]     core_distance,
  output logic [$clog2(K+1)-1:0] nbr_count,
  output logic [K*IDX_W-1:0]    nbr_idx,
  output logic [K*DATA_W-1:0]   nbr_dist
);
  localparam int CW = $clog2(K+1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, CALC, DONE} state_t;
  state_t state, state_n;
  logic [IDX_W:0]      n_lat;
  logic [IDX_W-1:0]    i;
  logic [DATA_W-1:0]   tp;
  logic [DATA_W-1:0]   dist_q [K];
  logic [IDX_W-1:0]    idx_q [K];
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       p;
  logic                last;
  assign last      = {1'b0, i} == n_lat - (IDX_W+1)'(1);
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign mem_ren   = state == FETCH;
  assign mem_addr  = i;
  assign core_en   = state == LOAD;
  assign core_A    = (state == LOAD) ? mem_rdata : '0;
  assign core_B    = tp;
  assign nbr_count = cnt;
  for (genvar g = 0; g < K; g++) begin : g_pack
    assign nbr_idx[g*IDX_W +: IDX_W]   = idx_q[g];
    assign nbr_dist[g*DATA_W +: DATA_W] = dist_q[g];
  end
  // insertion slot: number of valid entries not farther than the new distance (ties stay ahead)
  always_comb begin
    p = '0;
    for (int j = 0; j < K; j++)
      if (j < int'(cnt) && dist_q[j] <= core_distance) p = p + CW'(1);
  end
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? ((n_points == '0) ? DONE : FETCH) : IDLE;
      FETCH:   state_n = LOAD;
      LOAD:    state_n = CALC;
      CALC:    state_n = last ? DONE : FETCH;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  // scan bookkeeping and sorted neighbour list
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lat <= '0;
      i     <= '0;
      tp    <= '0;
      cnt   <= '0;
      for (int j = 0; j < K; j++) begin
        dist_q[j] <= '0;
        idx_q[j]  <= '0;
      end
    end else if (state == IDLE && start) begin
      n_lat <= n_points;
      tp    <= test_point;
      i     <= '0;
      cnt   <= '0;
    end else if (state == CALC) begin
      if (p < CW'(K)) begin
        for (int j = 0; j < K; j++)
          if (CW'(j) == p) begin
            dist_q[j] <= core_distance;
            idx_q[j]  <= i;
          end
        for (int j = 1; j < K; j++)
          if (CW'(j) > p) begin
            dist_q[j] <= dist_q[j-1];
            idx_q[j]  <= idx_q[j-1];
          end
      end
      if (cnt != CW'(K)) cnt <= cnt + CW'(1);
      if (!last) i <= i + IDX_W'(1);
    end
  end
endmodule

// File: doc/knn_ctrl.md
# knn_ctrl

Sequencing controller for the KNN distance core. It streams up to 2^IDX_W training points from a point memory through the distance core against one test point. It also keeps a sorted list of the K nearest points (distance and index). The block sits between the CPU-facing register interface (start, count, test point, results) and the combinational distance core plus the point RAM.

## Interface
- DATA_W, 32, point/distance width (x in [31:16], y in [15:0])
- IDX_W, 8, point index width; max 2^IDX_W points
- K, 4, number of neighbours kept (1..8)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- n_points  in  IDX_W+1  points to scan, sampled with start
- test_point  in  DATA_W  sampled with start and held internally
- busy  out  1  high from the cycle after start acceptance until DONE exits
- done  out  1  one-cycle pulse at end of scan
- mem_ren  out  1  point RAM read enable
- mem_addr  out  IDX_W  point RAM address
- mem_rdata  in  DATA_W  RAM data, valid the cycle after mem_ren
- core_en  out  1  load enable of distance core input registers
- core_A  out  DATA_W  training point (mem_rdata)
- core_B  out  DATA_W  registered test point
- core_distance  in  DATA_W  core result, valid the cycle after core_en
- nbr_count  out  $clog2(K+1)  valid list entries (0..K)
- nbr_idx  out  K*IDX_W  entry j at [j*IDX_W +: IDX_W], j=0 nearest
- nbr_dist  out  K*DATA_W  entry j at [j*DATA_W +: DATA_W]

## Operation
- FSM states: IDLE, FETCH, LOAD, CALC, DONE.
- **IDLE**
  - On start=1: latch n_points and test_point, set i=0, clear nbr_count.
  - Next state: FETCH, or DONE if n_points==0.
  - start in any other state is ignored.
- **FETCH:** mem_ren=1, mem_addr=i. Next state: LOAD.
- **LOAD:** core_en=1, core_A=mem_rdata, core_B=latched test point. Next state: CALC.
- **CALC:** core_distance belongs to point i; perform the insertion below.
  - If i==n_points-1: go to DONE.
  - Otherwise: i=i+1 and go to FETCH.
- **DONE:** done=1 for one cycle. Next state: IDLE.
- **Insertion:**
  - Let p = number of valid entries whose dist <= new distance (unsigned compare).
  - If p<K: entries p..K-2 shift to p+1..K-1, and the new entry (dist, i) is written at p.
  - nbr_count increments, saturating at K.
  - If p==K, the list is unchanged.
  - Ties: the earlier index stays nearer (stable order).
- Results stay stable from DONE until the next accepted start. Entries at positions >= nbr_count are don't-care, but must not change while nbr_count is unchanged.
- core_en, mem_ren and done are 0 in every state not listed above.

## Timing
- Start accepted at edge t: busy=1 from t+1.
- Cost is 3 cycles per point; done is high in the cycle after edge t+3N. busy falls together with done's deassertion.
- n_points=0: done high the cycle after edge t; nbr_count=0.
- Single-cycle insertion is comparator-parallel: K comparators plus a shift mux, with no extra cycles.
- Reset, asynchronous and also valid mid-scan:
  - state=IDLE, busy=0, done=0, mem_ren=0, core_en=0, mem_addr=0, core_A=0, core_B=0.
  - nbr_count=0, nbr_idx=0, nbr_dist=0, i=0.
  - A scan interrupted by reset is abandoned; there is no done pulse.
- Index wrap: n_points=2^IDX_W is legal. i reaches 2^IDX_W-1, and termination is on the equality compare, never on i overflow.

## Test plan
- **Empty scan:** start with n_points=0 → done one cycle after acceptance, busy high exactly one cycle, nbr_count=0, no mem_ren/core_en pulses.
- **Partial list:** test_point=0, points {(3,4),(1,0),(0,2)}, K=4 → done after 9 cycles; nbr_count=3; idx={1,2,0}; dist={1,4,25}.
- **Full list with eviction:** points {(3,4),(1,0),(0,2),(5,5),(1,1),(0,3)} → nbr_count=4; idx={1,4,2,5}; dist={1,2,4,9}. Points 0 and 3 are evicted.
- **Ties:** points {(0,2),(2,0),(0,2)}, all distance 4 → idx={0,1,2}, order preserved.
- **Restart:** pulse start during busy → ignored, scan length unchanged. A second start after done → list cleared, nbr_count restarts from 0.
- **Reset mid-scan:** assert rst in the LOAD state of point 2 → all outputs return to reset values immediately; no done. A new scan then completes normally.
